opcode_stream_rx: RTL and testbench

Parametrised successor to the GPU opcode collector. Assembles fixed-width opcodes from narrow per-beat chunks delivered on the GPU clock. Completed opcodes are buffered in a small FIFO and presented to the core array over a valid/ready handshake. Compared with the fixed two-beat, unbuffered collector, it adds configurable chunk and opcode widths, re-alignment via `sync`, buffering, backpressure, and overflow reporting.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/opcode_stream_rx.sv | 102 ++++++++++
 tb/tb_opcode_stream_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default opcode/chunk widths used by the opcode
// receive path and by the core array, plus the beats-per-opcode helper.
package gpu_pkg;

  localparam int OPCODE_W_DEFAULT = 16;
  localparam int CHUNK_W_DEFAULT  = 8;

  // Number of chunk beats needed to assemble one opcode.
  function automatic int beats_f(input int opcode_w, input int chunk_w);
    return opcode_w / chunk_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO. Owns storage and pointers. A push is
// accepted when not full, or when a pop happens in the same cycle; a pop
// with an empty FIFO is ignored.
module sync_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    full_s  = (level_r == LVL_W'(DEPTH));
    empty_s = (level_r == {LVL_W{1'b0}});
    rd_en_s = pop & ~empty_s;
    wr_en_s = push & (~full_s | rd_en_s);
  end

  // Storage write and write pointer; storage is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_in;
      wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Read pointer and occupancy count; simultaneous push and pop keeps level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/opcode_stream_rx.sv
// Opcode stream receiver: assembles OPCODE_W opcodes from CHUNK_W beats
// (first chunk in the MSBs), supports re-alignment via sync, buffers
// completed opcodes in a FIFO and flags dropped opcodes with a sticky
// overflow bit.
module opcode_stream_rx
  import gpu_pkg::*;
#(
  parameter int CHUNK_W  = CHUNK_W_DEFAULT,
  parameter int OPCODE_W = OPCODE_W_DEFAULT,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHUNK_W-1:0]       chunk_in,
  input  logic                     chunk_valid,
  input  logic                     sync,
  output logic [OPCODE_W-1:0]      opcode_out,
  output logic                     opcode_valid,
  input  logic                     opcode_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     partial,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int BEATS  = beats_f(OPCODE_W, CHUNK_W);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int ASM_W  = OPCODE_W - CHUNK_W;

  logic [ASM_W-1:0]  asm_r;
  logic [BEAT_W-1:0] beat_r;
  logic              overflow_r;
  logic              beat_last_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic [OPCODE_W-1:0] word_s;

  // Decode the completing beat and the push/pop/drop events.
  always_comb begin
    beat_last_s = (beat_r == BEAT_W'(BEATS - 1));
    word_s      = {asm_r, chunk_in};
    push_s      = chunk_valid & ~sync & beat_last_s;
    pop_s       = opcode_ready & ~empty_s;
    drop_s      = push_s & full_s & ~pop_s;
  end

  // Assembler shift register and beat counter; sync restarts alignment and
  // a coincident chunk becomes beat 0 of the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r  <= {ASM_W{1'b0}};
      beat_r <= {BEAT_W{1'b0}};
    end else if (sync) begin
      if (chunk_valid) begin
        asm_r  <= ASM_W'(chunk_in);
        beat_r <= BEAT_W'(1);
      end else begin
        asm_r  <= {ASM_W{1'b0}};
        beat_r <= {BEAT_W{1'b0}};
      end
    end else if (chunk_valid) begin
      asm_r  <= ASM_W'(word_s);
      beat_r <= beat_last_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (OPCODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (opcode_ready),
    .data_in (word_s),
    .head    (opcode_out),
    .level   (level),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign opcode_valid = ~empty_s;
  assign full         = full_s;
  assign partial      = (beat_r != {BEAT_W{1'b0}});
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_opcode_stream_rx.sv
// Scoreboard bench for opcode_stream_rx (CHUNK_W=8, OPCODE_W=16, DEPTH=4).
module tb_opcode_stream_rx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  chunk_in;
  logic        chunk_valid;
  logic        sync;
  logic [15:0] opcode_out;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [2:0]  level;
  logic        full;
  logic        partial;
  logic        overflow;
  logic        overflow_clr;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] sb_q[$];

  opcode_stream_rx #(.CHUNK_W(8), .OPCODE_W(16), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chunk_in     (chunk_in),
    .chunk_valid  (chunk_valid),
    .sync         (sync),
    .opcode_out   (opcode_out),
    .opcode_valid (opcode_valid),
    .opcode_ready (opcode_ready),
    .level        (level),
    .full         (full),
    .partial      (partial),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the active edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic s,
                       input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    chunk_valid  = v;
    chunk_in     = d;
    sync         = s;
    opcode_ready = rdy;
    overflow_clr = clr;
  endtask

  // Output side: every handshake pops the scoreboard and compares the head.
  always @(negedge clk) begin
    if (rst_n && opcode_valid && opcode_ready) begin
      check_val("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check_val("opcode", 32'(opcode_out), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 20)) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n++;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    check_val({tag, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; chunk_in = 8'h00; chunk_valid = 1'b0; sync = 1'b0;
    opcode_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    check_val("rst_valid", 32'(opcode_valid), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_out", 32'(opcode_out), 32'd0);
    check_val("rst_partial", 32'(partial), 32'd0);
    #20;
    rst_n = 1'b1;

    // Basic assembly
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(16'hA53C);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_val("basic_valid", 32'(opcode_valid), 32'd1);
    check_val("basic_level1", 32'(level), 32'd1);
    @(negedge clk);
    check_val("basic_valid_drop", 32'(opcode_valid), 32'd0);
    check_val("basic_level0", 32'(level), 32'd0);

    // Re-alignment
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(16'h2233);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_val("sync_partial", 32'(partial), 32'd0);
    drain("sync");

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i <= 4) sb_q.push_back(16'(i));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_val($sformatf("fill%0d_level", i), 32'(level), (i < 4) ? 32'(i) : 32'd4);
      check_val($sformatf("fill%0d_full", i), 32'(full), (i >= 4) ? 32'd1 : 32'd0);
      check_val($sformatf("fill%0d_ovf", i), 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end

    // Overflow clear
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("clr_ovf", 32'(overflow), 32'd0);

    // Push and pop while full
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(16'h0006);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("pp_full_level", 32'(level), 32'd4);
    check_val("pp_full_ovf", 32'(overflow), 32'd0);

    // Drop coinciding with clear: set wins
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("drop_clr_ovf", 32'(overflow), 32'd1);
    drain("fill");

    // Asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("pre_rst_level", 32'(level), 32'd2);
    check_val("pre_rst_partial", 32'(partial), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(opcode_valid), 32'd0);
    check_val("arst_level", 32'(level), 32'd0);
    check_val("arst_full", 32'(full), 32'd0);
    check_val("arst_partial", 32'(partial), 32'd0);
    check_val("arst_ovf", 32'(overflow), 32'd0);
    check_val("arst_out", 32'(opcode_out), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'hBE, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(16'hBEEF);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
